// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl
//   Decode-stage pipeline sequencer for a non-forwarding RV32I pipeline.
//   A small scoreboard remembers the destination registers of the instructions
//   still travelling through EX/MEM/WB. When the instruction in decode reads
//   one of them, the front end is held and a NOP is pushed into the
//   decode-to-execute register until the write becomes visible. It also owns
//   the EBREAK halt/resume state machine.
//
// Ports
//   clk          in   1            system clock, rising edge
//   reset        in   1            synchronous, active-high
//   iw_id        in   32           instruction word currently in decode
//   resume       in   1            single-cycle pulse that leaves HALT
//   stall_out    out  1            hold PC and IF/ID register (combinational)
//   bubble_out   out  1            decode latches NOP_IW into iw_out this cycle (combinational)
//   halt_out     out  1            registered, 1 while in HALT
//   stall_count  out  STALL_CNT_W  registered, saturating count of hazard-stall cycles
//
// Handshake with the decode stage: the instruction in decode advances on a
// clock edge exactly when stall_out=0 and bubble_out=0. stall_out=1 means
// "keep the same instruction in IF/ID"; bubble_out=1 means "send NOP_IW
// downstream instead of this instruction". An EBREAK is the one case with
// stall_out=0 and bubble_out=1: it leaves IF/ID but never reaches execute.

module rv32i_hazard_ctrl #(
    parameter int          PIPE_DEPTH  = 3,
    parameter int          STALL_CNT_W = 16,
    parameter logic [31:0] NOP_IW      = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            iw_id,
    input  logic                   resume,
    output logic                   stall_out,
    output logic                   bubble_out,
    output logic                   halt_out,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Decode of the instruction in ID
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       is_ebreak;
    logic       is_bubble;

    assign opcode    = iw_id[6:0];
    assign rs1       = iw_id[19:15];
    assign rs2       = iw_id[24:20];
    assign rd        = iw_id[11:7];
    assign is_ebreak = (iw_id == EBREAK_IW);
    // The injected bubble word never reads or writes the register file,
    // whatever encoding NOP_IW is given.
    assign is_bubble = (iw_id == NOP_IW);

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b1;
        case (opcode)
            OP_R, OP_BRANCH, OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LOAD, OP_IMM, OP_JALR: begin
                uses_rs1 = 1'b1;
            end
            default: begin
            end
        endcase
        if (opcode == OP_STORE || opcode == OP_BRANCH || opcode == OP_SYSTEM) begin
            writes_rd = 1'b0;
        end
        if (is_bubble) begin
            uses_rs1  = 1'b0;
            uses_rs2  = 1'b0;
            writes_rd = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: entry 0 is the instruction now in EX, the last entry the
    // one in WB. An entry shifted out past the end has written the register
    // file, so a reader in ID no longer has to wait for it.
    // ------------------------------------------------------------------
    logic [PIPE_DEPTH-1:0] sb_valid;
    logic [4:0]            sb_rd [PIPE_DEPTH];
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic                  hazard;
    logic                  advance;
    logic                  count_en;
    logic                  sb_load;

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_valid[i] && sb_rd[i] == rs1) rs1_hit = 1'b1;
            if (sb_valid[i] && sb_rd[i] == rs2) rs2_hit = 1'b1;
        end
    end

    // x0 is never tracked, so a read of x0 can never hazard.
    assign hazard = (uses_rs1 && rs1 != 5'd0 && rs1_hit) ||
                    (uses_rs2 && rs2 != 5'd0 && rs2_hit);

    assign sb_load = advance && writes_rd && (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_valid <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_rd[i] <= 5'd0;
            end
        end else begin
            sb_valid[0] <= sb_load;
            sb_rd[0]    <= sb_load ? rd : 5'd0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Halt FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Halt FSM: next state. An ebreak behind a hazard waits like any other
    // instruction and is only consumed once the hazard has cleared.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (is_ebreak && !hazard) state_next = HALT;
            HALT:    if (resume)               state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Halt FSM: outputs. While reset is high nothing is held, but only
    // bubbles are sent downstream.
    always_comb begin
        stall_out  = 1'b0;
        bubble_out = 1'b1;
        advance    = 1'b0;
        count_en   = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    stall_out  = hazard;
                    bubble_out = hazard | is_ebreak;
                    advance    = !hazard && !is_ebreak;
                    count_en   = hazard;
                end
                default: begin
                    stall_out  = 1'b1;
                    bubble_out = 1'b1;
                end
            endcase
        end
    end

    // halt_out is the state register itself, so it rises the cycle after
    // the ebreak is consumed and falls the cycle after resume.
    assign halt_out = (state == HALT);

    // ------------------------------------------------------------------
    // Hazard-stall performance counter (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (count_en && stall_count != {STALL_CNT_W{1'b1}}) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
